// File: rtl/cpu_obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI manager port among NHARTS hart ports, with in-order response routing.
// Optional per-hart grant and stall counters are built when CPU_ARB_PERF_EN is defined.
package cpu_obi_pkg;
    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module cpu_obi_rr_arbiter
    import cpu_obi_pkg::*;
#(
    parameter int NHARTS          = 3,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  obi_req_t    hart_req_i  [NHARTS],
    output obi_resp_t   hart_resp_o [NHARTS],
    output obi_req_t    mem_req_o,
    input  obi_resp_t   mem_resp_i,
`ifdef CPU_ARB_PERF_EN
    output logic [32*NHARTS-1:0] grant_cnt_o,
    output logic [31:0]          stall_cnt_o,
`endif
    output logic        busy_o,
    output logic        protocol_err_o
);
    localparam int IDX_W = $clog2(NHARTS);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [IDX_W-1:0] r_rr;
    logic             r_lock;
    logic [IDX_W-1:0] r_lockedIdx;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [IDX_W-1:0] r_fifo [MAX_OUTSTANDING];
    logic             r_protocolErr;

    logic [IDX_W-1:0] w_winner;
    logic [IDX_W-1:0] w_head;
    logic             w_found;
    logic             w_full;
    logic             w_memReq;
    logic             w_push;
    logic             w_pop;
    logic             w_spurious;

    function automatic logic [IDX_W-1:0] idxAdd(input logic [IDX_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NHARTS) sum = sum - NHARTS;
        return IDX_W'(sum);
    endfunction

    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // A stalled request stays locked to its hart so the presented transaction cannot change.
    always_comb begin
        w_winner = r_rr;
        w_found  = 1'b0;
        if (r_lock) begin
            w_winner = r_lockedIdx;
        end else begin
            for (int k = 0; k < NHARTS; k++) begin
                if (!w_found && hart_req_i[idxAdd(r_rr, k)].req) begin
                    w_found  = 1'b1;
                    w_winner = idxAdd(r_rr, k);
                end
            end
        end
    end

    assign w_full     = (r_count == CNT_W'(MAX_OUTSTANDING));
    assign w_memReq   = rst_ni & hart_req_i[w_winner].req & ~w_full;
    assign w_push     = w_memReq & mem_resp_i.gnt;
    assign w_pop      = mem_resp_i.rvalid & (r_count != '0);
    assign w_spurious = mem_resp_i.rvalid & (r_count == '0);
    assign w_head     = r_fifo[r_rdPtr];

    always_comb begin
        mem_req_o     = hart_req_i[w_winner];
        mem_req_o.req = w_memReq;
    end

    always_comb begin
        for (int i = 0; i < NHARTS; i++) begin
            hart_resp_o[i].rdata  = mem_resp_i.rdata;
            hart_resp_o[i].gnt    = w_push && (w_winner == IDX_W'(i));
            hart_resp_o[i].rvalid = w_pop && (w_head == IDX_W'(i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr          <= '0;
            r_lock        <= 1'b0;
            r_lockedIdx   <= '0;
            r_count       <= '0;
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
            r_protocolErr <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) r_fifo[i] <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wrPtr] <= w_winner;
                r_wrPtr         <= ptrInc(r_wrPtr);
                r_rr            <= idxAdd(w_winner, 1);
            end
            if (w_pop) r_rdPtr <= ptrInc(r_rdPtr);
            r_lock <= w_memReq & ~mem_resp_i.gnt;
            if (w_memReq && !mem_resp_i.gnt) r_lockedIdx <= w_winner;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_spurious) r_protocolErr <= 1'b1;
        end
    end

    assign busy_o         = (r_count != '0);
    assign protocol_err_o = r_protocolErr;

`ifdef CPU_ARB_PERF_EN
    logic w_anyReq;

    always_comb begin
        w_anyReq = 1'b0;
        for (int i = 0; i < NHARTS; i++) w_anyReq = w_anyReq | hart_req_i[i].req;
    end

    // Counters saturate rather than wrap so long runs never read back as small values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            for (int i = 0; i < NHARTS; i++) begin
                if (w_push && (w_winner == IDX_W'(i)) && (grant_cnt_o[32*i +: 32] != 32'hFFFF_FFFF))
                    grant_cnt_o[32*i +: 32] <= grant_cnt_o[32*i +: 32] + 32'd1;
            end
            if (w_anyReq && !w_push && (stall_cnt_o != 32'hFFFF_FFFF))
                stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`else
    // Performance counters are not present in this build.
`endif
endmodule
